// File: rtl/alu_pkg.sv
// Shared ALU definitions: controller state encoding, slice width and the
// alu_4bit mode/function-select encodings used by designs and benches.
package alu_pkg;

   localparam int unsigned SLICE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic MODE_ARITH = 1'b0;
   localparam logic MODE_LOGIC = 1'b1;

   localparam logic [3:0] FN_A      = 4'b0000;
   localparam logic [3:0] FN_AMB1   = 4'b0110;  // arith: A-B-1 (+cin); logic: A^B
   localparam logic [3:0] FN_ADD    = 4'b1001;  // arith: A+B (+cin); logic: ~(A^B)
   localparam logic [3:0] FN_AND    = 4'b1011;
   localparam logic [3:0] FN_OR     = 4'b1110;
   localparam logic [3:0] FN_AMIN1  = 4'b1111;

endpackage

// File: rtl/alu_4bit.sv
// 4-bit ALU slice, 74181-style function table with active-high carries.
// cout is always the arithmetic carry so slices chain identically in both modes.
module alu_4bit
   import alu_pkg::*;
(
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_cin,
   input  logic       i_m,
   input  logic [3:0] i_s,
   output logic [3:0] o_f,
   output logic       o_cout
);

   logic [3:0] w_x;
   logic [3:0] w_y;
   logic [3:0] w_lg;
   logic [4:0] w_sum;

   // Arithmetic functions are expressed as x + y + cin.
   always_comb begin
      w_x = i_a;
      w_y = '0;
      case (i_s)
         4'b0000: begin w_x = i_a;         w_y = '0;          end
         4'b0001: begin w_x = i_a | i_b;   w_y = '0;          end
         4'b0010: begin w_x = i_a | ~i_b;  w_y = '0;          end
         4'b0011: begin w_x = '0;          w_y = '1;          end
         4'b0100: begin w_x = i_a;         w_y = i_a & ~i_b;  end
         4'b0101: begin w_x = i_a | i_b;   w_y = i_a & ~i_b;  end
         4'b0110: begin w_x = i_a;         w_y = ~i_b;        end
         4'b0111: begin w_x = i_a & ~i_b;  w_y = '1;          end
         4'b1000: begin w_x = i_a;         w_y = i_a & i_b;   end
         4'b1001: begin w_x = i_a;         w_y = i_b;         end
         4'b1010: begin w_x = i_a | ~i_b;  w_y = i_a & i_b;   end
         4'b1011: begin w_x = i_a & i_b;   w_y = '1;          end
         4'b1100: begin w_x = i_a;         w_y = i_a;         end
         4'b1101: begin w_x = i_a | i_b;   w_y = i_a;         end
         4'b1110: begin w_x = i_a | ~i_b;  w_y = i_a;         end
         default: begin w_x = i_a;         w_y = '1;          end
      endcase
   end

   always_comb begin
      w_lg = '0;
      case (i_s)
         4'b0000: w_lg = ~i_a;
         4'b0001: w_lg = ~(i_a | i_b);
         4'b0010: w_lg = ~i_a & i_b;
         4'b0011: w_lg = '0;
         4'b0100: w_lg = ~(i_a & i_b);
         4'b0101: w_lg = ~i_b;
         4'b0110: w_lg = i_a ^ i_b;
         4'b0111: w_lg = i_a & ~i_b;
         4'b1000: w_lg = ~i_a | i_b;
         4'b1001: w_lg = ~(i_a ^ i_b);
         4'b1010: w_lg = i_b;
         4'b1011: w_lg = i_a & i_b;
         4'b1100: w_lg = '1;
         4'b1101: w_lg = i_a | ~i_b;
         4'b1110: w_lg = i_a | i_b;
         default: w_lg = i_a;
      endcase
   end

   assign w_sum  = {1'b0, w_x} + {1'b0, w_y} + {4'b0000, i_cin};
   assign o_f    = (i_m == MODE_LOGIC) ? w_lg : w_sum[3:0];
   assign o_cout = w_sum[4];

endmodule

// File: rtl/alu_nibble_seq.sv
// Nibble-serial wide ALU: one alu_4bit slice time-shared over NSLICE cycles,
// ripple carry held in a register between nibbles, start/done handshake.
module alu_nibble_seq
   import alu_pkg::*;
#(
   parameter  int unsigned NSLICE = 4,
   localparam int unsigned W      = SLICE_W * NSLICE
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   input  logic         m,
   input  logic [3:0]   s,
   output logic         ready,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         cout
);

   localparam int unsigned CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   state_t        r_state;
   state_t        w_state_next;
   logic [CW-1:0] r_cnt;
   logic          r_carry;
   logic [W-1:0]  r_a;
   logic [W-1:0]  r_b;
   logic          r_m;
   logic [3:0]    r_s;
   logic [W-1:0]  r_work;
   logic [W-1:0]  r_result;
   logic          r_cout;

   logic          w_ready;
   logic          w_busy;
   logic          w_done;
   logic          w_accept;
   logic [CW+1:0] w_sh;
   logic [W-1:0]  w_a_sh;
   logic [W-1:0]  w_b_sh;
   logic [3:0]    w_f;
   logic          w_cout;
   logic [W-1:0]  w_work_next;

   assign w_sh   = {r_cnt, 2'b00};
   assign w_a_sh = r_a >> w_sh;
   assign w_b_sh = r_b >> w_sh;

   alu_4bit u_slice (
      .i_a    (w_a_sh[3:0]),
      .i_b    (w_b_sh[3:0]),
      .i_cin  (r_carry),
      .i_m    (r_m),
      .i_s    (r_s),
      .o_f    (w_f),
      .o_cout (w_cout)
   );

   // Work value including the nibble being written this cycle, so the
   // final nibble can be committed to result on the same edge.
   always_comb begin
      w_work_next = r_work;
      w_work_next[w_sh +: SLICE_W] = w_f;
   end

   always_comb begin
      w_state_next = r_state;
      w_ready      = 1'b0;
      w_busy       = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_ready = 1'b1;
            if (start) w_state_next = ST_RUN;
         end
         ST_RUN: begin
            w_busy = 1'b1;
            if (r_cnt == LAST) w_state_next = ST_DONE;
         end
         ST_DONE: begin
            w_ready      = 1'b1;
            w_done       = 1'b1;
            w_state_next = start ? ST_RUN : ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   assign w_accept = w_ready & start;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_carry  <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_m      <= 1'b0;
         r_s      <= '0;
         r_work   <= '0;
         r_result <= '0;
         r_cout   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_m     <= m;
            r_s     <= s;
            r_carry <= cin;
            r_cnt   <= '0;
         end else if (r_state == ST_RUN) begin
            r_work  <= w_work_next;
            r_carry <= w_cout;
            if (r_cnt == LAST) begin
               r_cnt    <= '0;
               r_result <= w_work_next;
               r_cout   <= w_cout;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   assign ready  = w_ready;
   assign busy   = w_busy;
   assign done   = w_done;
   assign result = r_result;
   assign cout   = r_cout;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Self-checking bench for alu_nibble_seq against a full-width 16-bit ALU
// reference model; directed cases plus a randomized sweep.
module tb_alu_nibble_seq;
   import alu_pkg::*;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        m;
   logic [3:0]  s;
   logic        ready;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        cout;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   alu_nibble_seq #(.NSLICE(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .cin    (cin),
      .m      (m),
      .s      (s),
      .ready  (ready),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Whole-word 16-bit ALU: {cout, result}
   function automatic logic [16:0] ref_alu(input logic [15:0] ia, input logic [15:0] ib,
                                           input logic ic, input logic im, input logic [3:0] is);
      logic [15:0] x, y, lg;
      logic [16:0] sum;
      x = ia; y = 16'h0000; lg = 16'h0000;
      case (is)
         4'd0:  begin x = ia;       y = 16'h0000;  lg = ~ia;        end
         4'd1:  begin x = ia | ib;  y = 16'h0000;  lg = ~(ia | ib); end
         4'd2:  begin x = ia | ~ib; y = 16'h0000;  lg = ~ia & ib;   end
         4'd3:  begin x = 16'h0000; y = 16'hFFFF;  lg = 16'h0000;   end
         4'd4:  begin x = ia;       y = ia & ~ib;  lg = ~(ia & ib); end
         4'd5:  begin x = ia | ib;  y = ia & ~ib;  lg = ~ib;        end
         4'd6:  begin x = ia;       y = ~ib;       lg = ia ^ ib;    end
         4'd7:  begin x = ia & ~ib; y = 16'hFFFF;  lg = ia & ~ib;   end
         4'd8:  begin x = ia;       y = ia & ib;   lg = ~ia | ib;   end
         4'd9:  begin x = ia;       y = ib;        lg = ~(ia ^ ib); end
         4'd10: begin x = ia | ~ib; y = ia & ib;   lg = ib;         end
         4'd11: begin x = ia & ib;  y = 16'hFFFF;  lg = ia & ib;    end
         4'd12: begin x = ia;       y = ia;        lg = 16'hFFFF;   end
         4'd13: begin x = ia | ib;  y = ia;        lg = ia | ~ib;   end
         4'd14: begin x = ia | ~ib; y = ia;        lg = ia | ib;    end
         default: begin x = ia;     y = 16'hFFFF;  lg = ia;         end
      endcase
      sum = {1'b0, x} + {1'b0, y} + {16'h0000, ic};
      return {sum[16], im ? lg : sum[15:0]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation and wait (bounded) for done; checks result, cout, latency.
   task automatic do_op(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                        input logic im, input logic [3:0] is, input bit chk_lat, input string tag);
      logic [16:0] exp;
      int unsigned lat;
      int unsigned w;
      w = 0;
      while (!ready && w < 20) begin step(); w++; end
      if (!ready) check({tag, "_ready_timeout"}, 32'(ready), 32'd1);
      exp = ref_alu(ia, ib, ic, im, is);
      a = ia; b = ib; cin = ic; m = im; s = is; start = 1'b1;
      step();
      start = 1'b0;
      lat = 1;
      while (!done && lat < 20) begin step(); lat++; end
      check({tag, "_done_seen"}, 32'(done), 32'd1);
      if (chk_lat) check({tag, "_latency"}, lat, 32'd5);
      check({tag, "_result"}, 32'(result), 32'(exp[15:0]));
      check({tag, "_cout"}, 32'(cout), 32'(exp[16]));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [16:0] exp1;
      logic [16:0] qexp;
      logic [15:0] last_res;
      logic        last_cout;
      logic        expd;

      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; m = 1'b0; s = '0;
      step(); step();
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);

      // reset wins over start
      start = 1'b1;
      step();
      check("rst_vs_start_busy", 32'(busy), 32'd0);
      start = 1'b0;
      rst = 1'b0;
      step();

      // directed adds
      do_op(16'h0FFF, 16'h0001, 1'b0, MODE_ARITH, FN_ADD, 1'b1, "add_ripple");
      do_op(16'hFFFF, 16'h0001, 1'b0, MODE_ARITH, FN_ADD, 1'b1, "add_ovf");
      do_op(16'hFFFF, 16'h0000, 1'b1, MODE_ARITH, FN_ADD, 1'b1, "add_cin_ovf");
      do_op(16'h1234, 16'h1234, 1'b1, MODE_ARITH, FN_AMB1, 1'b1, "sub_eq");

      // done is one cycle, then IDLE with result held
      step();
      check("done_width", 32'(done), 32'd0);
      check("idle_ready", 32'(ready), 32'd1);
      check("hold_result", 32'(result), 32'h0000);

      // random sweep
      for (int i = 0; i < 2000; i++) begin
         do_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b1, "rand");
      end
      step();

      // start and input changes during RUN are ignored
      exp1 = ref_alu(16'h1234, 16'h0F0F, 1'b0, MODE_ARITH, FN_ADD);
      a = 16'h1234; b = 16'h0F0F; cin = 1'b0; m = MODE_ARITH; s = FN_ADD; start = 1'b1;
      step();
      start = 1'b0;
      check("run_busy", 32'(busy), 32'd1);
      check("run_ready", 32'(ready), 32'd0);
      step();
      start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; m = MODE_LOGIC; s = FN_OR;
      step();
      start = 1'b0; a = 16'hA5A5; b = 16'h5A5A; s = FN_AND;
      step();
      start = 1'b1; a = 16'h0001; b = 16'h0002; cin = 1'b0; m = MODE_ARITH; s = FN_AMIN1;
      step();
      start = 1'b0;
      check("ign_done", 32'(done), 32'd1);
      check("ign_result", 32'(result), 32'(exp1[15:0]));
      check("ign_cout", 32'(cout), 32'(exp1[16]));
      step();
      check("ign_no_requeue", 32'(busy), 32'd0);
      check("ign_hold", 32'(result), 32'(exp1[15:0]));

      // start held continuously: done every 5 cycles
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom_range(0, 1));
      m = 1'($urandom_range(0, 1)); s = 4'($urandom_range(0, 15));
      start = 1'b1;
      qexp = '0;
      last_res = result;
      last_cout = cout;
      for (int i = 1; i <= 31; i++) begin
         logic [16:0] cur;
         cur = ref_alu(a, b, cin, m, s);
         step();
         if (i % 5 == 1) qexp = cur;
         expd = (i % 5 == 0);
         check("cont_done", 32'(done), 32'(expd));
         if (expd) begin
            check("cont_result", 32'(result), 32'(qexp[15:0]));
            check("cont_cout", 32'(cout), 32'(qexp[16]));
            last_res = qexp[15:0];
            last_cout = qexp[16];
         end else begin
            check("cont_hold", 32'({last_cout, result}), 32'({cout, last_res}));
         end
         a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom_range(0, 1));
         m = 1'($urandom_range(0, 1)); s = 4'($urandom_range(0, 15));
      end
      start = 1'b0;
      repeat (6) step();

      // reset in RUN cycle 2 aborts
      do_op(16'h1234, 16'h1111, 1'b0, MODE_ARITH, FN_ADD, 1'b1, "pre_abort");
      a = 16'h4321; b = 16'h1111; cin = 1'b0; m = MODE_ARITH; s = FN_ADD; start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_ready", 32'(ready), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_result", 32'(result), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      for (int i = 0; i < 8; i++) begin
         step();
         check("abort_no_done", 32'(done), 32'd0);
      end
      do_op(16'h8000, 16'h8000, 1'b1, MODE_ARITH, FN_ADD, 1'b1, "post_abort");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
